// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one single-port memory between the
// core MEM stage and the host port, with host starvation protection.
module dmem_arbiter #(
    parameter int ADDR_W        = 16,
    parameter int DATA_W        = 32,
    parameter int HOST_MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_stall,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_rvalid,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_rvalid,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_CORE = 2'b01,
        OWN_HOST = 2'b10
    } owner_e;

    localparam logic [3:0] MAX_WAIT = 4'(HOST_MAX_WAIT);

    if (HOST_MAX_WAIT < 1 || HOST_MAX_WAIT > 15) begin : g_bad_wait
        $error("dmem_arbiter: HOST_MAX_WAIT must lie in 1..15");
    end

    logic [3:0] wait_cnt;
    logic [3:0] wait_nxt;
    owner_e     rd_owner;
    owner_e     owner_nxt;
    logic       host_prio;
    logic       core_gnt;

    // Same-cycle arbitration; nothing is granted while reset is held.
    always_comb begin
        host_prio  = (wait_cnt == MAX_WAIT);
        core_gnt   = rst_n & core_req & ~(host_req & host_prio);
        host_gnt   = rst_n & host_req & ~core_gnt;
        core_stall = core_req & ~core_gnt;
    end

    // Steer the granted requester onto the memory port.
    always_comb begin
        mem_en    = core_gnt | host_gnt;
        mem_we    = 1'b0;
        mem_addr  = host_addr;
        mem_wdata = host_wdata;
        if (core_gnt) begin
            mem_we    = core_we;
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
        end else if (host_gnt) begin
            mem_we    = host_we;
        end
    end

    // Next starvation count and owner of the read issued this cycle.
    always_comb begin
        wait_nxt  = wait_cnt;
        owner_nxt = OWN_NONE;
        if (host_gnt || !host_req) begin
            wait_nxt = 4'd0;
        end else if (wait_cnt < MAX_WAIT) begin
            wait_nxt = wait_cnt + 4'd1;
        end
        if (core_gnt && !core_we) begin
            owner_nxt = OWN_CORE;
        end else if (host_gnt && !host_we) begin
            owner_nxt = OWN_HOST;
        end
    end

    // State registers; reset drops any read still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= 4'd0;
            rd_owner <= OWN_NONE;
        end else begin
            wait_cnt <= wait_nxt;
            rd_owner <= owner_nxt;
        end
    end

    // Read data goes to both sides; the valid picks the owner.
    always_comb begin
        core_rvalid = (rd_owner == OWN_CORE);
        host_rvalid = (rd_owner == OWN_HOST);
        core_rdata  = mem_rdata;
        host_rdata  = mem_rdata;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed checks, then random traffic
// compared every cycle against a grant-order behavioural model.
module tb_dmem_arbiter;

    localparam int AW   = 16;
    localparam int DW   = 32;
    localparam int MAXW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          core_req = 1'b0;
    logic          core_we = 1'b0;
    logic [AW-1:0] core_addr = '0;
    logic [DW-1:0] core_wdata = '0;
    logic          core_stall;
    logic [DW-1:0] core_rdata;
    logic          core_rvalid;
    logic          host_req = 1'b0;
    logic          host_we = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic [DW-1:0] host_wdata = '0;
    logic          host_gnt;
    logic [DW-1:0] host_rdata;
    logic          host_rvalid;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    int total = 0;
    int bad = 0;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .HOST_MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst_n(rst_n),
        .core_req(core_req), .core_we(core_we),
        .core_addr(core_addr), .core_wdata(core_wdata),
        .core_stall(core_stall), .core_rdata(core_rdata),
        .core_rvalid(core_rvalid),
        .host_req(host_req), .host_we(host_we),
        .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rdata(host_rdata),
        .host_rvalid(host_rvalid),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Environment memory: single port, 1-cycle read latency.
    logic [DW-1:0] env_mem [256];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) env_mem[mem_addr[7:0]] <= mem_wdata;
            else        mem_rdata <= env_mem[mem_addr[7:0]];
        end
    end

    // Behavioural model: a denied-streak count, a shadow memory
    // updated in grant order, and the single pending read.
    logic [DW-1:0] mdl_mem [256];
    int            streak;
    int            pend;
    logic [DW-1:0] pend_data;
    logic          ex_h;
    logic          ex_c;

    assign ex_h = rst_n && host_req && (!core_req || streak == MAXW);
    assign ex_c = rst_n && core_req && !ex_h;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak <= 0;
            pend   <= 0;
        end else begin
            if (ex_h || !host_req) streak <= 0;
            else streak <= (streak + 1 > MAXW) ? MAXW : streak + 1;
            pend <= 0;
            if (ex_c) begin
                if (core_we) mdl_mem[core_addr[7:0]] <= core_wdata;
                else begin
                    pend      <= 1;
                    pend_data <= mdl_mem[core_addr[7:0]];
                end
            end else if (ex_h) begin
                if (host_we) mdl_mem[host_addr[7:0]] <= host_wdata;
                else begin
                    pend      <= 2;
                    pend_data <= mdl_mem[host_addr[7:0]];
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("core_stall", 32'(core_stall), 32'(core_req && !ex_c));
        chk("host_gnt", 32'(host_gnt), 32'(ex_h));
        chk("mem_en", 32'(mem_en), 32'(ex_c || ex_h));
        chk("mem_we", 32'(mem_we),
            32'((ex_c && core_we) || (ex_h && host_we)));
        if (ex_c || ex_h) begin
            chk("mem_addr", 32'(mem_addr),
                32'(ex_c ? core_addr : host_addr));
            if (mem_we)
                chk("mem_wdata", mem_wdata,
                    ex_c ? core_wdata : host_wdata);
        end
        chk("core_rvalid", 32'(core_rvalid), 32'(rst_n && pend == 1));
        chk("host_rvalid", 32'(host_rvalid), 32'(rst_n && pend == 2));
        if (rst_n && pend == 1) chk("core_rdata", core_rdata, pend_data);
        if (rst_n && pend == 2) chk("host_rdata", host_rdata, pend_data);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic core_set(input logic r, input logic w,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        core_req = r; core_we = w; core_addr = a; core_wdata = d;
    endtask

    task automatic host_set(input logic r, input logic w,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        host_req = r; host_we = w; host_addr = a; host_wdata = d;
    endtask

    logic cs_seen;
    logic hg_seen;

    initial begin
        for (int i = 0; i < 256; i++) begin
            logic [DW-1:0] v;
            v = $urandom;
            env_mem[i] = v;
            mdl_mem[i] = v;
        end
        env_mem[8'h10] = 32'hDEADBEEF; mdl_mem[8'h10] = 32'hDEADBEEF;
        env_mem[1] = 32'h000000A1;     mdl_mem[1] = 32'h000000A1;
        env_mem[2] = 32'h000000A2;     mdl_mem[2] = 32'h000000A2;
        env_mem[3] = 32'h000000A3;     mdl_mem[3] = 32'h000000A3;

        #1 rst_n = 1'b0;
        core_set(1'b1, 1'b0, 16'h0010, '0);
        @(negedge clk);
        chk("rst_core_stall", 32'(core_stall), 32'd1);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_host_gnt", 32'(host_gnt), 32'd0);
        chk("rst_core_rvalid", 32'(core_rvalid), 32'd0);
        core_set(1'b0, 1'b0, '0, '0);
        step();
        rst_n = 1'b1;
        step();

        // Core-only load.
        core_set(1'b1, 1'b0, 16'h0010, '0);
        @(negedge clk);
        chk("ld_mem_en", 32'(mem_en), 32'd1);
        chk("ld_stall", 32'(core_stall), 32'd0);
        step();
        core_set(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk("ld_rvalid", 32'(core_rvalid), 32'd1);
        chk("ld_rdata", core_rdata, 32'hDEADBEEF);
        chk("ld_host_rvalid", 32'(host_rvalid), 32'd0);
        step();

        // Host write then read back.
        host_set(1'b1, 1'b1, 16'h0020, 32'h12345678);
        @(negedge clk);
        chk("hw_gnt", 32'(host_gnt), 32'd1);
        step();
        host_set(1'b1, 1'b0, 16'h0020, '0);
        @(negedge clk);
        chk("hr_gnt", 32'(host_gnt), 32'd1);
        step();
        host_set(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk("hr_rvalid", 32'(host_rvalid), 32'd1);
        chk("hr_rdata", host_rdata, 32'h12345678);
        step();

        // Contention until the host is starved, then served once.
        core_set(1'b1, 1'b0, 16'h0004, '0);
        host_set(1'b1, 1'b0, 16'h0005, '0);
        for (int c = 1; c <= MAXW; c++) begin
            @(negedge clk);
            chk("starve_core_win", 32'(core_stall), 32'd0);
            chk("starve_host_wait", 32'(host_gnt), 32'd0);
            if (c == 2) chk("wait_cnt_one", 32'(dut.wait_cnt), 32'd1);
            step();
            core_addr = core_addr + 16'd1;
        end
        @(negedge clk);
        chk("starve_host_gnt", 32'(host_gnt), 32'd1);
        chk("starve_core_stall", 32'(core_stall), 32'd1);
        step();
        host_set(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk("resume_core", 32'(core_stall), 32'd0);
        chk("resume_wait_cnt", 32'(dut.wait_cnt), 32'd0);
        step();

        // Back-to-back core loads.
        for (int a = 1; a <= 3; a++) begin
            core_set(1'b1, 1'b0, AW'(a), '0);
            @(negedge clk);
            chk("b2b_stall", 32'(core_stall), 32'd0);
            if (a > 1) begin
                chk("b2b_rvalid", 32'(core_rvalid), 32'd1);
                chk("b2b_rdata", core_rdata, 32'h000000A0 + 32'(a - 1));
            end
            step();
        end
        core_set(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk("b2b_rvalid_last", 32'(core_rvalid), 32'd1);
        chk("b2b_rdata_last", core_rdata, 32'h000000A3);
        step();

        // Reset while a load return is pending.
        core_set(1'b1, 1'b0, 16'h0010, '0);
        step();
        core_set(1'b0, 1'b0, '0, '0);
        chk("pre_rst_rvalid", 32'(core_rvalid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rvalid_drop", 32'(core_rvalid), 32'd0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_wait", 32'(dut.wait_cnt), 32'd0);
        chk("post_rst_rvalid", 32'(core_rvalid | host_rvalid), 32'd0);
        step();

        // Random traffic; requesters hold until serviced.
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            cs_seen = core_stall;
            hg_seen = host_gnt;
            step();
            if (!(core_req && cs_seen)) begin
                core_set(($urandom % 10) < 6, $urandom % 2,
                         AW'($urandom % 64), $urandom);
            end
            if (!(host_req && !hg_seen)) begin
                host_set(($urandom % 10) < 5, $urandom % 2,
                         AW'($urandom % 64), $urandom);
            end
        end
        core_set(1'b0, 1'b0, '0, '0);
        host_set(1'b0, 1'b0, '0, '0);
        step();
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the core's single-port data memory between two requesters.
- Requester 0 is the pipeline MEM stage (ldm/stm). Requester 1 is the host port (program/data loader, debug readback).
- Grants one access per cycle, stalls the loser, and routes 1-cycle-latency read data back to the owner.
- Uses a starvation counter so the host cannot be locked out by a store/load-heavy program.

Parameters:
- ADDR_W, 16, word-address width to memory.
- DATA_W, 32, data width.
- HOST_MAX_WAIT, 4, consecutive denied host cycles before the host takes priority (1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- core_req  in  1  core access request (ldm or stm in MEM stage).
- core_we  in  1  1 = store, 0 = load.
- core_addr  in  ADDR_W  core word address.
- core_wdata  in  DATA_W  core store data.
- core_stall  out  1  core request not serviced this cycle; pipeline must hold.
- core_rdata  out  DATA_W  load data.
- core_rvalid  out  1  core_rdata valid (cycle after a granted core load).
- host_req  in  1  host request; host_we/addr/wdata held stable until granted.
- host_we  in  1  host write enable.
- host_addr  in  ADDR_W  host word address.
- host_wdata  in  DATA_W  host write data.
- host_gnt  out  1  host request accepted this cycle.
- host_rdata  out  DATA_W  host read data.
- host_rvalid  out  1  host_rdata valid (cycle after a granted host read).
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid 1 cycle after mem_en & ~mem_we.

Behaviour:
- Registers:
  - wait_cnt[3:0]: host starvation counter.
  - rd_owner[1:0]: 00 none, 01 core, 10 host. Records the owner of the read issued last cycle.
- Reset (rst_n low, asynchronous):
  - wait_cnt=0, rd_owner=00.
  - core_rvalid=0, host_rvalid=0, host_gnt=0, mem_en=0, mem_we=0.
  - core_stall follows core_req (no grants while in reset).
  - Data outputs are don't-care.
- Arbitration (combinational, same cycle):
  - host_prio = (wait_cnt == HOST_MAX_WAIT).
  - core_gnt = core_req & ~(host_req & host_prio).
  - host_gnt = host_req & ~core_gnt.
  - core_stall = core_req & ~core_gnt.
- Memory mux:
  - mem_en = core_gnt | host_gnt.
  - mem_we, mem_addr and mem_wdata are taken from the granted requester.
  - With no grant: mem_we=0; mem_addr and mem_wdata are don't-care.
- wait_cnt update, at each clock:
  - host_gnt or ~host_req: cleared to 0.
  - Otherwise host_req & ~host_gnt: incremented, saturating at HOST_MAX_WAIT.
- Read return:
  - At each clock, rd_owner is set to 01 for a granted core load, 10 for a granted host read, and 00 otherwise (including writes).
  - core_rvalid = (rd_owner==01); host_rvalid = (rd_owner==10).
  - core_rdata and host_rdata both wire to mem_rdata; only the matching rvalid qualifies them.
- Latency:
  - Grant is 0 cycles.
  - Read data arrives 1 cycle after grant.
  - Writes commit at the grant edge.
- Simultaneous requests:
  - Core wins unless host_prio, in which case the host wins exactly once.
  - The resulting host_gnt clears wait_cnt, so the core wins on the next cycle.
- Write then read, same address:
  - Ordering is the grant order.
  - The memory is read-after-write safe across cycles; there is no same-cycle conflict because there is one grant per cycle.
- A core read return and a new core grant may occur in the same cycle (back-to-back loads); rd_owner reflects the newest grant.
- Reset mid-read: the pending rvalid is dropped and not replayed.
- HOST_MAX_WAIT is checked with an elaboration-time assertion to lie in 1..15.

Test Plan:
- Core only: core load addr 0x0010 (mem holds 0xDEADBEEF) -> mem_en=1 and core_stall=0 in cycle N; core_rvalid=1 with core_rdata=0xDEADBEEF in N+1; host_rvalid=0.
- Host only: host write 0x0020 <- 0x12345678, then host read 0x0020 -> host_gnt=1 both cycles; host_rvalid=1 with 0x12345678 one cycle after the read grant.
- Conflict, no starvation: core_req and host_req both high with wait_cnt=0 -> core granted, host_gnt=0, wait_cnt=1 next cycle.
- Starvation, HOST_MAX_WAIT=4: core_req and host_req held high continuously -> 4 core grants, then host_gnt=1 with core_stall=1 on cycle 5, then core resumes on cycle 6 with wait_cnt=0.
- Back-to-back core loads to 0x1, 0x2, 0x3 -> core_rvalid high for 3 consecutive cycles with data in order and no stalls.
- Reset mid-op: assert rst_n=0 in the cycle after a granted core load -> core_rvalid=0 immediately (asynchronous); after release, wait_cnt=0 and no spurious rvalid.
